pushbutton_conditioner: RTL and testbench

//   Input stage for the 4-bit uP. Conditions raw, asynchronous, bouncing pushbuttons.

---
 rtl/pb_pkg.sv | 13 +
 rtl/pushbutton_conditioner_if.sv | 21 ++
 rtl/pb_debounce_bit.sv | 90 +++++++++
 rtl/pushbutton_conditioner.sv | 49 ++++
 tb/tb_pushbutton_conditioner.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/pb_pkg.sv
// pb_pkg: shared pushbutton conditioner types and default sizes, also used by the uP top
package pb_pkg;
    localparam int PB_WIDTH           = 4;
    localparam int PB_SYNC_STAGES     = 2;
    localparam int PB_DEBOUNCE_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } pb_state_e;
endpackage

// File: rtl/pushbutton_conditioner_if.sv
// pushbutton_conditioner_if: raw button inputs, conditioned outputs and event clear mask
interface pushbutton_conditioner_if import pb_pkg::*; #(
    parameter int WIDTH = PB_WIDTH
);
    logic [WIDTH-1:0] pb_raw;
    logic [WIDTH-1:0] event_clr;
    logic [WIDTH-1:0] pb_stable;
    logic [WIDTH-1:0] pb_rise;
    logic [WIDTH-1:0] pb_fall;
    logic [WIDTH-1:0] pb_event;

    modport master (
        output pb_raw, event_clr,
        input  pb_stable, pb_rise, pb_fall, pb_event
    );

    modport slave (
        input  pb_raw, event_clr,
        output pb_stable, pb_rise, pb_fall, pb_event
    );
endinterface

// File: rtl/pb_debounce_bit.sv
// pb_debounce_bit: one-bit synchronizer plus debounce FSM with saturating sample counter
module pb_debounce_bit import pb_pkg::*; #(
    parameter int SYNC_STAGES     = PB_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
    input  logic clock,
    input  logic reset,
    input  logic pb_raw,
    output logic stable,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    pb_state_e              state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pb_raw};
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        case (state_q)
            IDLE_LO: if (s) begin
                state_d = WAIT_HI;
                cnt_d   = CNT_ONE;
            end
            WAIT_HI: if (!s) begin
                state_d = IDLE_LO;
                cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
                state_d  = IDLE_HI;
                cnt_d    = '0;
                stable_d = 1'b1;
                rise_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            IDLE_HI: if (!s) begin
                state_d = WAIT_LO;
                cnt_d   = CNT_ONE;
            end
            WAIT_LO: if (s) begin
                state_d = IDLE_HI;
                cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
                state_d  = IDLE_LO;
                cnt_d    = '0;
                stable_d = 1'b0;
                fall_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            default: state_d = IDLE_LO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q   <= '0;
            state_q  <= IDLE_LO;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;
    assign fall   = fall_q;
endmodule

// File: rtl/pushbutton_conditioner.sv
// pushbutton_conditioner: per-bit debounced buttons with rise/fall strobes;
// sticky press flags only when PB_EVENT_LATCH_EN is defined
module pushbutton_conditioner import pb_pkg::*; #(
    parameter int WIDTH           = PB_WIDTH,
    parameter int SYNC_STAGES     = PB_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = PB_DEBOUNCE_CYCLES
) (
    input logic                     clock,
    input logic                     reset,
    pushbutton_conditioner_if.slave pb
);
    logic [WIDTH-1:0] stable_w, rise_w, fall_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        pb_debounce_bit #(
            .SYNC_STAGES(SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_bit (
            .clock(clock),
            .reset(reset),
            .pb_raw(pb.pb_raw[i]),
            .stable(stable_w[i]),
            .rise(rise_w[i]),
            .fall(fall_w[i])
        );
    end

    assign pb.pb_stable = stable_w;
    assign pb.pb_rise   = rise_w;
    assign pb.pb_fall   = fall_w;

`ifdef PB_EVENT_LATCH_EN
    logic [WIDTH-1:0] event_q, event_d;

    // OR-ing the set after the clear lets a coincident press survive its clear
    always_comb event_d = (event_q & ~pb.event_clr) | rise_w;

    always_ff @(posedge clock) begin
        if (!reset) event_q <= '0;
        else        event_q <= event_d;
    end

    assign pb.pb_event = event_q;
`else
    logic unused_event_clr;
    assign unused_event_clr = &{1'b0, pb.event_clr};
    assign pb.pb_event = '0;
`endif
endmodule

// File: tb/tb_pushbutton_conditioner.sv
// tb_pushbutton_conditioner: table-driven cycle vectors checked through an expectation queue
module tb_pushbutton_conditioner;
    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    pushbutton_conditioner_if #(.WIDTH(4)) pb_if ();

    pushbutton_conditioner #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pb(pb_if.slave)
    );

    typedef struct {
        int         n;
        logic       rst_n;
        logic [3:0] raw;
        logic [3:0] clr;
        logic [3:0] stable;
        logic [3:0] rise;
        logic [3:0] fall;
    } row_t;

    typedef struct {
        int         cyc;
        logic [3:0] stable;
        logic [3:0] rise;
        logic [3:0] fall;
        logic [3:0] ev;
    } exp_t;

    row_t tbl[$];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    logic [3:0] ev_model   = 4'h0;
    logic [3:0] prev_rise  = 4'h0;

    task automatic add(input int n, input logic r, input logic [3:0] raw, input logic [3:0] clr,
                       input logic [3:0] st, input logic [3:0] ri, input logic [3:0] fa);
        row_t x;
        x.n = n; x.rst_n = r; x.raw = raw; x.clr = clr;
        x.stable = st; x.rise = ri; x.fall = fa;
        tbl.push_back(x);
    endtask

    task automatic check(input string name, input int c, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, c, act, req);
        end
    endtask

    task automatic compare_pop();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("pb_stable", e.cyc, pb_if.pb_stable, e.stable);
            check("pb_rise", e.cyc, pb_if.pb_rise, e.rise);
            check("pb_fall", e.cyc, pb_if.pb_fall, e.fall);
            check("pb_event", e.cyc, pb_if.pb_event, e.ev);
            check("rise_fall_overlap", e.cyc, pb_if.pb_rise & pb_if.pb_fall, 4'h0);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b0;
        pb_if.pb_raw = 4'h0;
        pb_if.event_clr = 4'h0;
        // 1: reset with all pressed, then debounce all high, then release all
        add(3, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'hF, 4'h0, 4'hF, 4'hF, 4'h0);
        add(2, 1, 4'hF, 4'h0, 4'hF, 4'h0, 4'h0);
        add(6, 1, 4'h0, 4'h0, 4'hF, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF);
        add(3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // 2: short glitch on bit 0 rejected
        add(2, 1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);
        add(10, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // 3: bit 1 bounces 1,0,1,1,0 then holds
        add(1, 1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(2, 1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0);
        add(3, 1, 4'h2, 4'h0, 4'h2, 4'h0, 4'h0);
        // 4: bit 1 release
        add(6, 1, 4'h0, 4'h0, 4'h2, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2);
        add(3, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        // 5: bit 2 press, clear on a quiet cycle, then clear coincident with a rise
        add(6, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0);
        add(2, 1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
        add(1, 1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0);
        add(2, 1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
        add(6, 1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4);
        add(1, 1, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 1, 4'h4, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h4, 4'h0, 4'h4, 4'h4, 4'h0);
        add(1, 1, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0);
        add(2, 1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
        add(1, 1, 4'h4, 4'hF, 4'h4, 4'h0, 4'h0);
        add(1, 1, 4'h4, 4'h0, 4'h4, 4'h0, 4'h0);
        // 6: reset while bit 3 is mid-debounce (cnt=3), then re-debounce
        add(5, 1, 4'hC, 4'h0, 4'h4, 4'h0, 4'h0);
        add(2, 0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        add(6, 1, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0);
        add(1, 1, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0);
        add(3, 1, 4'h8, 4'h0, 4'h8, 4'h0, 4'h0);

        foreach (tbl[k]) begin
            for (int j = 0; j < tbl[k].n; j++) begin
                @(negedge clock);
                compare_pop();
                reset = tbl[k].rst_n;
                pb_if.pb_raw = tbl[k].raw;
                pb_if.event_clr = tbl[k].clr;
                // prev_rise is the strobe visible on the output while this clear is applied
                ev_model = tbl[k].rst_n ? ((ev_model & ~tbl[k].clr) | prev_rise) : 4'h0;
                prev_rise = tbl[k].rst_n ? tbl[k].rise : 4'h0;
                cyc++;
                e.cyc = cyc;
                e.stable = tbl[k].stable;
                e.rise = tbl[k].rise;
                e.fall = tbl[k].fall;
`ifdef PB_EVENT_LATCH_EN
                e.ev = ev_model;
`else
                e.ev = 4'h0;
`endif
                sb.push_back(e);
            end
        end
        @(negedge clock);
        compare_pop();
        check("scoreboard_drained", cyc, 4'(sb.size()), 4'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
